// File: rtl/seq_detect_param.sv
// Moore serial-pattern detector: runtime-loadable PAT_W-bit pattern, KMP fallback, overlap mode, saturating match counter.
// Latency: y/progress/match_count are registered and change one edge after the sampling edge; there is no backpressure (en qualifies each bit).
module seq_detect_param #(
    parameter int                PAT_W    = 4,
    parameter logic [PAT_W-1:0]  PAT_INIT = 4'b1011,
    parameter int                CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       x,
    input  logic                       load,
    input  logic [PAT_W-1:0]           pat_in,
    input  logic                       overlap,
    output logic                       y,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(PAT_W+1)-1:0] progress
);

    localparam int SW = $clog2(PAT_W + 1);
    localparam logic [SW-1:0] MATCH = SW'(PAT_W);

    logic [SW-1:0]    state;
    logic [SW-1:0]    nxt;
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] cnt;

    // Bit i in stream order: i=0 is the first pattern bit expected (pat[PAT_W-1]).
    function automatic logic pbit(input logic [PAT_W-1:0] p, input int i);
        logic [PAT_W-1:0] s;
        s = p >> (PAT_W - 1 - i);
        return s[0];
    endfunction

    // The last k consumed bits equal the first k pattern bits, so the history is
    // implied by k alone: pick the longest prefix j that is a suffix of that history plus x.
    function automatic logic [SW-1:0] kmp_next(input logic [PAT_W-1:0] p, input int k,
                                               input logic xb);
        logic [SW-1:0] r;
        logic          ok;
        int            idx;
        r = '0;
        for (int j = 1; j <= PAT_W; j++) begin
            ok = (j <= k + 1) && (pbit(p, j - 1) == xb);
            for (int t = 0; t < PAT_W - 1; t++) begin
                idx = k - j + 1 + t;
                if (t < j - 1 && idx >= 0 && idx < PAT_W) begin
                    if (pbit(p, t) != pbit(p, idx)) ok = 1'b0;
                end
            end
            if (ok) r = SW'(j);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= '0;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (load) begin
            nxt = '0;
        end else if (en) begin
            if (state == MATCH && !overlap) nxt = kmp_next(pat, 0, x);
            else                            nxt = kmp_next(pat, int'(state), x);
        end
    end

    always_comb begin
        y        = (state == MATCH);
        progress = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat <= PAT_INIT;
            cnt <= '0;
        end else if (load) begin
            pat <= pat_in;
            cnt <= '0;
        end else if (en && nxt == MATCH && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign match_count = cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed stimulus with hand-computed expectations queued per edge; a negedge monitor pops and compares.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       load = 1'b0;
    logic [3:0] pat_in = 4'h0;
    logic       overlap = 1'b1;
    logic       y;
    logic [7:0] match_count;
    logic [2:0] progress;
    logic       y2;
    logic [1:0] cnt2;
    logic [2:0] prog2;

    logic       ov_sel = 1'b1;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pat_in(pat_in),
        .overlap(overlap), .y(y), .match_count(match_count), .progress(progress)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .x(x), .load(load), .pat_in(pat_in),
        .overlap(overlap), .y(y2), .match_count(cnt2), .progress(prog2)
    );

    typedef struct {
        string      name;
        logic       ey;
        logic [2:0] ep;
        logic [7:0] ec;
        logic       chk2;
        logic [1:0] ec2;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic push(input string nm, input logic [2:0] ep, input logic [7:0] ec,
                        input logic c2);
        exp_t e;
        e.name = nm;
        e.ep   = ep;
        e.ey   = (ep == 3'd4);
        e.ec   = ec;
        e.chk2 = c2;
        e.ec2  = (ec > 8'd3) ? 2'd3 : ec[1:0];
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({y, progress, match_count} !== {e.ey, e.ep, e.ec} ||
                (e.chk2 && {y2, prog2, cnt2} !== {e.ey, e.ep, e.ec2})) begin
                $display("FAIL %s: got y=%0b progress=%0d count=%0d y2=%0b count2=%0d, want y=%0b progress=%0d count=%0d count2=%0d",
                         e.name, y, progress, match_count, y2, cnt2, e.ey, e.ep, e.ec, e.ec2);
            end else begin
                passes++;
            end
        end
    end

    task automatic step(input string nm, input logic e, input logic xb, input logic ld,
                        input logic [3:0] p, input logic [2:0] ep, input logic [7:0] ec,
                        input logic c2);
        @(negedge clk);
        en      = e;
        x       = xb;
        load    = ld;
        pat_in  = p;
        overlap = ov_sel;
        @(posedge clk);
        push(nm, ep, ec, c2);
    endtask

    // Strings give the bit stream and the expected progress/count after each bit.
    task automatic seq(input string nm, input string xs, input string ps, input string cs,
                       input logic c2);
        for (int i = 0; i < xs.len(); i++) begin
            step(nm, 1'b1, xs[i] == 8'd49, 1'b0, 4'h0, 3'(ps[i] - 8'd48),
                 8'(cs[i] - 8'd48), c2);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        @(posedge clk);
        push("reset", 3'd0, 8'd0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        ov_sel = 1'b1;
        seq("ovl_1011", "1011011", "1234234", "0001112", 1'b0);

        do_reset();
        ov_sel = 1'b0;
        seq("novl_1011", "1011011", "1234011", "0001111", 1'b0);

        step("load_1111", 1'b1, 1'b1, 1'b1, 4'b1111, 3'd0, 8'd0, 1'b0);
        ov_sel = 1'b1;
        seq("ones_ovl", "111111", "123444", "000123", 1'b0);
        step("reload_1111", 1'b1, 1'b0, 1'b1, 4'b1111, 3'd0, 8'd0, 1'b0);
        ov_sel = 1'b0;
        seq("ones_novl", "111111", "123412", "000111", 1'b0);

        ov_sel = 1'b1;
        step("load_1011", 1'b0, 1'b0, 1'b1, 4'b1011, 3'd0, 8'd0, 1'b0);
        step("gap_b1",  1'b1, 1'b1, 1'b0, 4'h0, 3'd1, 8'd0, 1'b0);
        step("gap_h1a", 1'b0, 1'b0, 1'b0, 4'h0, 3'd1, 8'd0, 1'b0);
        step("gap_h1b", 1'b0, 1'b1, 1'b0, 4'h0, 3'd1, 8'd0, 1'b0);
        step("gap_b2",  1'b1, 1'b0, 1'b0, 4'h0, 3'd2, 8'd0, 1'b0);
        step("gap_h2a", 1'b0, 1'b0, 1'b0, 4'h0, 3'd2, 8'd0, 1'b0);
        step("gap_h2b", 1'b0, 1'b1, 1'b0, 4'h0, 3'd2, 8'd0, 1'b0);
        step("gap_b3",  1'b1, 1'b1, 1'b0, 4'h0, 3'd3, 8'd0, 1'b0);
        step("gap_h3",  1'b0, 1'b0, 1'b0, 4'h0, 3'd3, 8'd0, 1'b0);
        step("gap_b4",  1'b1, 1'b1, 1'b0, 4'h0, 3'd4, 8'd1, 1'b0);
        step("hold_m1", 1'b0, 1'b0, 1'b0, 4'h0, 3'd4, 8'd1, 1'b0);
        step("hold_m2", 1'b0, 1'b1, 1'b0, 4'h0, 3'd4, 8'd1, 1'b0);
        step("exit_m",  1'b1, 1'b1, 1'b0, 4'h0, 3'd1, 8'd1, 1'b0);

        seq("pre_load", "01", "23", "11", 1'b0);
        step("load_0110", 1'b1, 1'b0, 1'b1, 4'b0110, 3'd0, 8'd0, 1'b0);
        seq("pat_0110", "0110", "1234", "0001", 1'b0);

        // Reset pulse wholly between clock edges with en low.
        @(negedge clk);
        en = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        push("async_reset", 3'd0, 8'd0, 1'b0);
        seq("post_reset", "1011", "1234", "0001", 1'b0);

        do_reset();
        ov_sel = 1'b1;
        seq("saturate", "1011011011011011", "1234234234234234", "0001112223334445", 1'b1);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised Moore serial-pattern detector with a runtime-loadable pattern, overlap/non-overlap mode and a saturating match counter. It generalises the team's fixed five-state single-input Moore FSMs: one serial input bit per enabled clock, a registered state, and outputs that depend only on state. It sits on a serial bit stream and flags occurrences of a PAT_W-bit pattern for downstream control logic.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PAT_INIT, 4'b1011 (PAT_W bits), pattern loaded at reset.
- CNT_W, 8, match counter width.
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  bit-valid; x is consumed only on edges where en=1.
- x  input  1  serial data bit.
- load  input  1  pattern-load strobe.
- pat_in  input  PAT_W  new pattern, captured when load=1.
- overlap  input  1  1 = overlapping detection, 0 = restart after match.
- y  output  1  match flag (Moore): 1 while FSM is in MATCH state.
- match_count  output  CNT_W  number of matches since reset/load, saturating.
- progress  output  $clog2(PAT_W+1)  current matched-prefix length (state).

## Operation
- Pattern order: pat[PAT_W-1] is the first bit expected, pat[0] the last.
- State k = 0..PAT_W = length of longest pattern prefix that is a suffix of bits consumed so far; k=PAT_W is MATCH.
- Reset (async): state=0, pattern register=PAT_INIT, match_count=0, so y=0, progress=0.
- Enabled edge (en=1, load=0), from state k<PAT_W: if x equals pat[PAT_W-1-k], k -> k+1; else k -> longest j<=k such that the first j-1 pattern bits equal the last j-1 of the k matched bits and bit j-1 equals x (KMP fallback); j may be 0.
- From MATCH with overlap=1: next state computed as above from the longest proper suffix of the pattern that is also a prefix, then applying x.
- From MATCH with overlap=0: matched history discarded; x treated as first bit: next state 1 if x==pat[PAT_W-1], else 0.
- en=0 and load=0: state, pattern, counter hold; y holds (MATCH persists while en low).
- load=1: pattern register <= pat_in, state <= 0, match_count <= 0; x and en ignored that edge (load has priority).
- overlap is sampled every edge; a change takes effect on the next transition out of MATCH.
- match_count increments by 1 on each edge that enters MATCH; it holds at 2^CNT_W-1 when saturated (no wrap).
- y = (state == PAT_W); progress = state; no combinational path from x, en or load to any output.

## Timing
- Latency: y rises the cycle after the edge that samples the final pattern bit; it remains high for exactly one cycle if en stays 1 and the next bit does not re-complete the pattern.
- match_count updates on the same edge that makes y rise.
- Back-to-back MATCH is possible only via overlap=1 with a self-overlapping pattern of all-equal bits (e.g. 1111): y stays high across consecutive matches and the counter increments each edge.
- Reset asserted mid-stream clears everything asynchronously, independent of clk; first bit after deassertion is treated as stream start.
- Load with en=1 on the same edge: bit lost, not counted.

## Test plan
- Reset then PAT_INIT=1011, overlap=1, en=1, stream 1,0,1,1,0,1,1 -> y high in cycles after bits 4 and 7, match_count=2, progress after bit 5 = 2.
- Same stream with overlap=0 -> single match after bit 4, match_count=1, progress after bit 7 = 1.
- Pattern 1111 loaded, overlap=1, six 1s -> y high for 3 consecutive cycles, match_count=3; with overlap=0 -> matches after bits 4 only (bits 5-6 give progress 2), count=1.
- en toggling: 1,0,1 with en=0 gaps inserted and x toggling during gaps, then 1 -> exactly one match, gaps do not disturb progress; y held high while en=0 in MATCH.
- load mid-stream at progress=3 with pat_in=0110 -> progress=0, count=0, then stream 0,1,1,0 -> one match; async reset pulse between clock edges -> y, progress, count go 0 immediately, pattern back to 1011.
- CNT_W=2 instance, five matches -> match_count saturates at 3, y still pulses on every match.
